// File: rtl/dmem_sramlike_bridge_if.sv
// SRAM-like data bus between the MEM-stage bridge (master) and the memory
// slave. One request in flight; the address is accepted with data_addr_ok and
// completed with data_data_ok.
interface dmem_sramlike_bridge_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_sel;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  // Handshake: data_req stays high until the slave returns data_addr_ok in
  // the same cycle; request fields are stable for that whole window. A later
  // (or the same) cycle with data_data_ok completes it; data_rdata is valid
  // only in that cycle.
  modport master (
    output data_req, data_wr, data_size, data_sel, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_sel, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/dmem_sramlike_bridge.sv
// Bridge from the CPU MEM stage to an SRAM-like data bus. It latches one
// access, holds the pipeline until it completes, then waits out pipeline stalls.
module dmem_sramlike_bridge (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cpu_en,
  input  logic                           cpu_we,
  input  logic [3:0]                     cpu_sel,
  input  logic [1:0]                     cpu_size,
  input  logic [31:0]                    cpu_addr,
  input  logic [31:0]                    cpu_wdata,
  input  logic                           cpu_longest_stall,
  output logic [31:0]                    cpu_rdata,
  output logic                           cpu_stall,
  output logic [1:0]                     dbg_state,
  dmem_sramlike_bridge_if.master         bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state, next_state;
  logic        latch_req;
  logic        capture;
  logic        req_we;
  logic [1:0]  req_size;
  logic [3:0]  req_sel;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [31:0] rbuf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    latch_req  = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_en) begin
          next_state = ADDR;
          latch_req  = 1'b1;
        end
      end
      ADDR: begin
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            next_state = DONE;
            capture    = ~req_we;
          end else begin
            next_state = DATA;
          end
        end
      end
      DATA: begin
        if (bus.data_data_ok) begin
          next_state = DONE;
          capture    = ~req_we;
        end
      end
      DONE: begin
        if (!cpu_longest_stall) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The request register is only written from IDLE, so CPU-side changes while
  // a request is in flight never reach the bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_we    <= 1'b0;
      req_size  <= 2'd0;
      req_sel   <= 4'd0;
      req_addr  <= 32'd0;
      req_wdata <= 32'd0;
    end else if (latch_req) begin
      req_we    <= cpu_we;
      req_size  <= cpu_size;
      req_sel   <= cpu_sel;
      req_addr  <= cpu_addr;
      req_wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)         rbuf <= 32'd0;
    else if (capture) rbuf <= bus.data_rdata;
  end

  assign bus.data_req   = (state == ADDR);
  assign bus.data_wr    = req_we;
  assign bus.data_size  = req_size;
  assign bus.data_sel   = req_sel;
  assign bus.data_addr  = req_addr;
  assign bus.data_wdata = req_wdata;

  assign cpu_rdata = rbuf;
  // Gated by reset so a held cpu_en cannot stall the pipeline while in reset.
  assign cpu_stall = rst & ((cpu_en & (state == IDLE)) | (state == ADDR) | (state == DATA));
  assign dbg_state = state;

endmodule

// File: tb/tb_dmem_sramlike_bridge.sv
// Bench for dmem_sramlike_bridge: directed vector table, reset corner cases
// and randomized transactions against a transaction-level reference model.
module tb_dmem_sramlike_bridge;

  logic        clk;
  logic        rst;
  logic        cpu_en;
  logic        cpu_we;
  logic [3:0]  cpu_sel;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_longest_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [1:0]  dbg_state;

  dmem_sramlike_bridge_if bus ();

  dmem_sramlike_bridge dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_en            (cpu_en),
    .cpu_we            (cpu_we),
    .cpu_sel           (cpu_sel),
    .cpu_size          (cpu_size),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_longest_stall (cpu_longest_stall),
    .cpu_rdata         (cpu_rdata),
    .cpu_stall         (cpu_stall),
    .dbg_state         (dbg_state),
    .bus               (bus)
  );

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          addr_wait;
    int          data_wait;
    logic        same;
    int          done_stall;
    logic        b2b;
    logic [31:0] exp_rdata;
    int          exp_req;
    int          exp_stall;
  } txn_t;

  txn_t        vec[7];
  int          n_vec;
  int          n_bad;
  logic [31:0] model_rdata;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver: one full transaction ----------------
  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic run_txn(input string tag, input txn_t t);
    int   req_cnt, stall_cnt, dcnt;
    logic granted, got_data;
    req_cnt = 0; stall_cnt = 0; dcnt = 0;
    granted = 1'b0; got_data = 1'b0;
    cpu_en = 1'b1; cpu_we = t.we; cpu_size = t.size; cpu_sel = t.sel;
    cpu_addr = t.addr; cpu_wdata = t.wdata; cpu_longest_stall = 1'b0;
    for (int k = 0; k < 60 && !got_data; k++) begin
      bus.data_addr_ok = 1'b0;
      bus.data_data_ok = 1'b0;
      bus.data_rdata   = $urandom;
      if (k == 0) begin
        bus.data_data_ok = 1'($urandom_range(0, 1));
      end else if (k == 1) begin
        cpu_we = ~t.we; cpu_size = 2'($urandom_range(0, 2)); cpu_sel = ~t.sel;
        cpu_addr = ~t.addr; cpu_wdata = ~t.wdata;
      end
      if (bus.data_req) begin
        if (req_cnt == t.addr_wait) begin
          bus.data_addr_ok = 1'b1;
          granted = 1'b1;
          if (t.same) begin
            bus.data_data_ok = 1'b1;
            bus.data_rdata   = t.rdata;
            got_data = 1'b1;
          end
        end
      end else if (granted) begin
        if (dcnt == t.data_wait) begin
          bus.data_data_ok = 1'b1;
          bus.data_rdata   = t.rdata;
          got_data = 1'b1;
        end
        dcnt++;
      end
      @(negedge clk);
      if (k == 0) check({tag, " idle_no_req"}, 32'(bus.data_req), 32'd0);
      if (cpu_stall) stall_cnt++;
      if (bus.data_req) begin
        req_cnt++;
        check({tag, " addr"},  bus.data_addr,  t.addr);
        check({tag, " wdata"}, bus.data_wdata, t.wdata);
        check({tag, " wr"},    32'(bus.data_wr),   32'(t.we));
        check({tag, " size"},  32'(bus.data_size), 32'(t.size));
        check({tag, " sel"},   32'(bus.data_sel),  32'(t.sel));
      end
      check({tag, " rdata_hold"}, cpu_rdata, model_rdata);
      @(posedge clk); #1;
    end
    if (!got_data) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      return;
    end
    if (!t.we) model_rdata = t.rdata;
    // Spurious completion while in DONE must be ignored.
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b1;
    bus.data_rdata   = 32'h0BAD_0BAD;
    for (int d = 0; d <= t.done_stall; d++) begin
      cpu_longest_stall = (d < t.done_stall);
      @(negedge clk);
      check({tag, " done_state"}, 32'(dbg_state), 32'(S_DONE));
      check({tag, " done_stall0"}, 32'(cpu_stall), 32'd0);
      check({tag, " done_no_req"}, 32'(bus.data_req), 32'd0);
      check({tag, " done_rdata"}, cpu_rdata, t.exp_rdata);
      @(posedge clk); #1;
      bus.data_data_ok = 1'b0;
    end
    cpu_longest_stall = 1'b0;
    check({tag, " req_cycles"},   32'(req_cnt),   32'(t.exp_req));
    check({tag, " stall_cycles"}, 32'(stall_cnt), 32'(t.exp_stall));
    if (!t.b2b) begin
      cpu_en = 1'b0;
      @(negedge clk);
      check({tag, " back_idle"}, 32'(dbg_state), 32'(S_IDLE));
      check({tag, " idle_stall0"}, 32'(cpu_stall), 32'd0);
      @(posedge clk); #1;
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [1:0] size, input logic [3:0] sel,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int aw, input int dw,
                              input logic same, input int ds, input logic b2b,
                              input logic [31:0] exp_rdata, input int exp_req,
                              input int exp_stall);
    txn_t t;
    t.we = we; t.size = size; t.sel = sel; t.addr = addr; t.wdata = wdata;
    t.rdata = rdata; t.addr_wait = aw; t.data_wait = dw; t.same = same;
    t.done_stall = ds; t.b2b = b2b; t.exp_rdata = exp_rdata;
    t.exp_req = exp_req; t.exp_stall = exp_stall;
    return t;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    txn_t r;
    n_vec = 0; n_bad = 0; model_rdata = 32'd0;
    rst = 1'b0; cpu_en = 1'b1; cpu_we = 1'b1; cpu_sel = 4'hF; cpu_size = 2'd2;
    cpu_addr = 32'h1234_5678; cpu_wdata = 32'h9ABC_DEF0; cpu_longest_stall = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'd0;

    // Reset state, with cpu_en held high to show the stall is gated.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst state", 32'(dbg_state), 32'(S_IDLE));
    check("rst data_req", 32'(bus.data_req), 32'd0);
    check("rst data_wr", 32'(bus.data_wr), 32'd0);
    check("rst data_addr", bus.data_addr, 32'd0);
    check("rst data_wdata", bus.data_wdata, 32'd0);
    check("rst data_size", 32'(bus.data_size), 32'd0);
    check("rst cpu_rdata", cpu_rdata, 32'd0);
    check("rst cpu_stall", 32'(cpu_stall), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; cpu_en = 1'b0;
    @(posedge clk); #1;

    // Directed vectors; expected values written from the protocol timing.
    vec[0] = mk(1'b0, 2'd2, 4'hF, 32'h8000_0010, 32'h0, 32'hDEAD_BEEF, 0, 0, 1'b0, 0, 1'b0,
                32'hDEAD_BEEF, 1, 3);
    vec[1] = mk(1'b1, 2'd1, 4'b0011, 32'h8000_0020, 32'h0000_1234, 32'h5555_5555, 3, 1, 1'b0, 0, 1'b0,
                32'hDEAD_BEEF, 4, 7);
    vec[2] = mk(1'b0, 2'd2, 4'hF, 32'h8000_0104, 32'h0, 32'hCAFE_F00D, 1, 2, 1'b0, 5, 1'b0,
                32'hCAFE_F00D, 2, 6);
    vec[3] = mk(1'b0, 2'd2, 4'hF, 32'h0000_0008, 32'h0, 32'h1111_2222, 0, 0, 1'b1, 0, 1'b0,
                32'h1111_2222, 1, 2);
    vec[4] = mk(1'b0, 2'd0, 4'b0100, 32'h0000_0042, 32'h0, 32'h3333_4444, 2, 0, 1'b1, 1, 1'b0,
                32'h3333_4444, 3, 4);
    vec[5] = mk(1'b0, 2'd2, 4'hF, 32'h0000_0010, 32'h0, 32'hA5A5_A5A5, 0, 0, 1'b0, 0, 1'b1,
                32'hA5A5_A5A5, 1, 3);
    vec[6] = mk(1'b1, 2'd2, 4'hF, 32'h0000_0014, 32'hFFFF_0000, 32'h7777_7777, 0, 0, 1'b0, 0, 1'b0,
                32'hA5A5_A5A5, 1, 3);
    for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vec[i]);

    // Reset while in DATA, then a late completion that must be ignored.
    cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0100; cpu_size = 2'd2; cpu_sel = 4'hF;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b1;
    @(posedge clk); #1;
    bus.data_addr_ok = 1'b0;
    @(negedge clk);
    check("mid in_data", 32'(dbg_state), 32'(S_DATA));
    rst = 1'b0;
    #1;
    check("mid data_req", 32'(bus.data_req), 32'd0);
    check("mid cpu_stall", 32'(cpu_stall), 32'd0);
    check("mid state", 32'(dbg_state), 32'(S_IDLE));
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;
    rst = 1'b1; cpu_en = 1'b0;
    @(posedge clk); #1;
    bus.data_data_ok = 1'b0;
    @(negedge clk);
    check("mid late_ok rdata", cpu_rdata, 32'd0);
    check("mid late_ok state", 32'(dbg_state), 32'(S_IDLE));
    model_rdata = 32'd0;
    @(posedge clk); #1;

    // Random transactions; expectations from the transaction-level model.
    for (int i = 0; i < 40; i++) begin
      r.we = 1'($urandom_range(0, 1));
      r.size = 2'($urandom_range(0, 2));
      r.sel = 4'($urandom);
      r.addr = $urandom;
      r.wdata = $urandom;
      r.rdata = $urandom;
      r.addr_wait = $urandom_range(0, 4);
      r.data_wait = $urandom_range(0, 3);
      r.same = ($urandom_range(0, 3) == 0);
      r.done_stall = $urandom_range(0, 3);
      r.b2b = 1'($urandom_range(0, 1));
      r.exp_rdata = r.we ? model_rdata : r.rdata;
      r.exp_req = r.addr_wait + 1;
      r.exp_stall = 1 + (r.addr_wait + 1) + (r.same ? 0 : r.data_wait + 1);
      run_txn($sformatf("rnd%0d", i), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_sramlike_bridge.md
DMEM_SRAMLIKE_BRIDGE -- requirements
Module: dmem_sramlike_bridge

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst. Port list:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-low (0 = reset)
- cpu_en  in  1  memory access request from MEM stage (mem_en)
- cpu_we  in  1  store when 1, load when 0 (mem_we)
- cpu_sel  in  4  byte-lane enables (sel)
- cpu_size  in  2  0 = byte, 1 = half, 2 = word (mem_size)
- cpu_addr  in  32  byte address
- cpu_wdata  in  32  store data, lane-aligned (mem_wdata_last)
- cpu_longest_stall  in  1  OR of all pipeline stall sources
- cpu_rdata  out  32  load data returned to MEM stage
- cpu_stall  out  1  stall request to hazard unit (stallreq_from_mem)
- data_req  out  1  sram-like request valid
- data_wr  out  1  1 = write
- data_size  out  2  copy of cpu_size
- data_addr  out  32  request address
- data_wdata  out  32  write data
- data_addr_ok  in  1  slave accepted the address
- data_data_ok  in  1  read data valid or write complete
- data_rdata  in  32  read data

Function
REQ-002 FSM states SHALL be IDLE, ADDR, DATA, DONE.
REQ-003 IDLE: if cpu_en = 1, go to ADDR and latch cpu_we, cpu_size, cpu_addr, cpu_wdata into a request register.
REQ-004 ADDR: data_req = 1 and data_wr/size/addr/wdata come from the request register. On data_addr_ok = 1, go to DATA.
REQ-005 ADDR with data_addr_ok and data_data_ok both 1 in the same cycle: go directly to DONE and capture data_rdata.
REQ-006 DATA: data_req = 0. On data_data_ok = 1, capture data_rdata into the read buffer (loads only) and go to DONE.
REQ-007 DONE: stay in DONE while cpu_longest_stall = 1. Go to IDLE in the first cycle cpu_longest_stall = 0. No new request is issued from DONE.
REQ-008 cpu_stall SHALL be (cpu_en & state == IDLE) | state == ADDR | state == DATA. It is 0 in DONE.
REQ-009 cpu_rdata SHALL be the read buffer, held stable from the DONE entry until the next load's data_data_ok.
REQ-010 Stores SHALL leave the read buffer unchanged.
REQ-011 Only one outstanding transaction. data_data_ok received in IDLE or DONE SHALL be ignored.
REQ-012 cpu_sel is a qualifier for the slave-side mask. data_wdata SHALL pass unmodified. data_size SHALL equal the latched cpu_size.
REQ-013 Changes to cpu_* inputs while in ADDR or DATA SHALL NOT alter data_addr, data_wdata, data_wr or data_size.
REQ-014 data_req SHALL be registered-state-derived (no combinational path from data_addr_ok).
REQ-015 Latency for a zero-wait slave (addr_ok in the issue cycle, data_ok one cycle later):
- cpu_stall high for 3 cycles (IDLE, ADDR, DATA).
- Data available in DONE.

Reset
REQ-016 While rst = 0:
- state = IDLE
- data_req = 0, data_wr = 0
- data_addr = 0, data_wdata = 0, data_size = 0
- cpu_rdata = 0
- cpu_stall = 0
REQ-017 Reset asserted mid-transaction SHALL abandon it immediately. A late data_data_ok after reset SHALL be ignored per REQ-011.

Verification
REQ-018 Load, zero-wait slave:
- Stimulus: cpu_en = 1, cpu_we = 0, addr 0x8000_0010, slave returns 0xDEAD_BEEF.
- Required: cpu_rdata = 0xDEADBEEF in DONE; cpu_stall high for exactly 3 cycles; one data_req pulse, one cycle wide.
REQ-019 Store with wait states:
- Stimulus: cpu_we = 1, sel 4'b0011, size 1, wdata 0x0000_1234; addr_ok delayed 3 cycles, data_ok 2 cycles later.
- Required: data_req held 4 cycles with stable addr, data_size = 1, data_wr = 1; cpu_rdata unchanged.
REQ-020 External stall in DONE:
- Stimulus: cpu_longest_stall held 1 for 5 cycles after data_ok.
- Required: the FSM holds DONE with cpu_stall = 0 and no second data_req; it returns to IDLE the cycle the stall drops.
REQ-021 Same-cycle handshake:
- Stimulus: data_addr_ok = data_data_ok = 1 in the ADDR cycle, rdata 0x1111_2222.
- Required: direct ADDR->DONE; cpu_rdata = 0x11112222.
REQ-022 Reset mid-transaction:
- Stimulus: rst = 0 while in DATA.
- Required: data_req = 0, cpu_stall = 0 immediately; a following data_data_ok is ignored and cpu_rdata stays 0.
REQ-023 Back-to-back load then store:
- Stimulus: a load then a store, with cpu_longest_stall = 0 between them.
- Required: two separate transactions; the second is issued only after one IDLE cycle.
